// File: rtl/alu_result_fifo.sv
// alu_result_fifo: show-ahead FIFO for 5-bit {Cout, O} results from the ALU/shifter
// datapath, drained to the consumer through a valid/ready handshake.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   in_o, in_cout      offered result {in_cout, in_o}
//   in_valid/in_ready  producer handshake (in_ready = not full)
//   out_o, out_cout    head entry (0 while empty)
//   out_zero           head present and out_o == 0
//   out_valid/out_ready consumer handshake (out_valid = not empty)
//   count              stored entries, 0..DEPTH
//   ovf, clr_ovf       sticky drop flag and its synchronous clear
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    in_o,
  input  logic          in_cout,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [3:0]    out_o,
  output logic          out_cout,
  output logic          out_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          ovf,
  input  logic          clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 5;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Handshake status comes only from registered count.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != CW'(0));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Show-ahead head entry, forced to zero while empty since storage is never cleared.
  assign head      = out_valid ? mem_q[rd_ptr_q] : EW'(0);
  assign out_cout  = head[4];
  assign out_o     = head[3:0];
  assign out_zero  = out_valid & (head[3:0] == 4'b0000);
  assign count     = count_q;
  assign ovf       = ovf_q;

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (in_valid && !in_ready) ovf_d = 1'b1;
    else if (clr_ovf)          ovf_d = 1'b0;
  end

  // Control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_cout, in_o};
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    in_o;
  logic          in_cout;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    out_o;
  logic          out_cout;
  logic          out_zero;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          ovf;
  logic          clr_ovf;

  int checks   = 0;
  int failures = 0;

  logic [4:0] exp_q [$];

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_o      (in_o),
    .in_cout   (in_cout),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_o     (out_o),
    .out_cout  (out_cout),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one accepted result for one cycle; expected entry goes to the scoreboard.
  task automatic push_one(input logic c, input logic [3:0] o);
    in_valid = 1'b1; in_cout = c; in_o = o;
    exp_q.push_back({c, o});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  // Monitor: whenever a pop is presented, compare the head with the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {27'd0, out_cout, out_o}, 32'hFFFF_FFFF);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("pop_data", {27'd0, out_cout, out_o}, {27'd0, e});
        chk("pop_zero", {31'd0, out_zero}, {31'd0, (e[3:0] == 4'd0)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_o = '0; in_cout = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_count",     32'(count),     0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  {27'd0, out_cout, out_o}, 0);
    chk("rst_out_zero",  32'(out_zero),  0);
    chk("rst_ovf",       32'(ovf),       0);

    // Fill in push order
    push_one(1'b0, 4'h3);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_head",  {27'd0, out_cout, out_o}, 32'h03);
    push_one(1'b1, 4'h0);
    push_one(1'b0, 4'hF);
    push_one(1'b1, 4'h9);
    chk("full_count",    32'(count),    4);
    chk("full_in_ready", 32'(in_ready), 0);

    // Drop while full, then clear/set collision, then clear alone
    in_valid = 1'b1; in_cout = 1'b0; in_o = 4'h7;
    tick();
    chk("ovf_set",     32'(ovf),   1);
    chk("ovf_count",   32'(count), 4);
    clr_ovf = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(ovf), 1);
    in_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);

    drain(4);
    chk("drain_count",  32'(count),     0);
    chk("drain_valid",  32'(out_valid), 0);
    chk("drain_data",   {27'd0, out_cout, out_o}, 0);
    chk("drain_zero",   32'(out_zero),  0);
    chk("drain_sb",     32'(exp_q.size()), 0);

    // Simultaneous push/pop at count=2 across pointer wrap
    push_one(1'b0, 4'h1);
    push_one(1'b1, 4'h2);
    chk("sim_pre_count", 32'(count), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_cout = i[0]; in_o = 4'(i + 3);
      exp_q.push_back({i[0], 4'(i + 3)});
      tick();
      chk("sim_count", 32'(count), 2);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    out_ready = 1'b0;
    chk("sim_end_count", 32'(count), 0);

    // Full with pop: pop only, push accepted next cycle
    push_one(1'b0, 4'hA);
    push_one(1'b1, 4'hB);
    push_one(1'b0, 4'hC);
    push_one(1'b1, 4'hD);
    in_valid = 1'b1; in_cout = 1'b0; in_o = 4'hE; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fp_count", 32'(count), 3);
    chk("fp_ovf",   32'(ovf),   1);
    exp_q.push_back({1'b0, 4'hE});
    tick();
    in_valid = 1'b0;
    chk("fp_push_count", 32'(count), 4);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("fp_ovf_clr", 32'(ovf), 0);
    drain(4);
    chk("fp_sb", 32'(exp_q.size()), 0);

    // Reset mid-traffic, asserted asynchronously mid-cycle
    push_one(1'b1, 4'h4);
    push_one(1'b0, 4'h6);
    push_one(1'b1, 4'h8);
    chk("mr_pre_count", 32'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_count",    32'(count),     0);
    chk("mr_valid",    32'(out_valid), 0);
    chk("mr_in_ready", 32'(in_ready),  1);
    chk("mr_data",     {27'd0, out_cout, out_o}, 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    push_one(1'b1, 4'h5);
    chk("mr_head_valid", 32'(out_valid), 1);
    chk("mr_head",       {27'd0, out_cout, out_o}, 32'h15);
    drain(1);

    // Bounded wait for scoreboard to empty
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("final_sb",    32'(exp_q.size()), 0);
    chk("final_count", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
